game_session_ctrl: RTL

GAME_SESSION_CTRL -- requirements
Module: game_session_ctrl

---
 rtl/game_session_ctrl_pkg.sv | 44 ++++
 rtl/game_session_ctrl_if.sv | 26 ++
 rtl/game_session_ctrl_seq_divider.sv | 72 +++++++
 rtl/game_session_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/game_session_ctrl_pkg.sv
// Shared game definitions for the typing-session controller: top-level game
// state codes, mode codes, display constants and the BCD formatting helper.
package game_session_ctrl_pkg;

  localparam int unsigned SAT_MAX = 127;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned WPM_W   = 13;

  localparam logic [3:0]  BLANK_DIGIT = 4'hC;
  localparam logic [15:0] BLANK_DISP  = {4{BLANK_DIGIT}};

  typedef enum logic [1:0] {
    GS_SELECT    = 2'd0,
    GS_COUNTDOWN = 2'd1,
    GS_INGAME    = 2'd2,
    GS_FINISH    = 2'd3
  } game_state_e;

  typedef enum logic {
    MODE_TIME  = 1'b0,
    MODE_WORDS = 1'b1
  } game_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CALC,
    S_DONE
  } sess_state_e;

  // Double-dabble conversion to four BCD digits, clamping at 9999.
  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sh;
    sh = {16'd0, ((bin > 14'd9999) ? 14'd9999 : bin)};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
      end
      sh = sh << 1;
    end
    return sh[29:14];
  endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Handshake/status bundle between the game top level and the session controller.
interface game_session_ctrl_if;
  import game_session_ctrl_pkg::*;

  logic [1:0]       state;
  logic             mode;
  logic [CNT_W-1:0] value;
  logic             word_done;
  logic             finish;
  logic [CNT_W-1:0] elapsed_s;
  logic [CNT_W-1:0] words;
  logic [WPM_W-1:0] wpm;
  logic             wpm_valid;
  logic [15:0]      disp;

  modport master (
    output state, mode, value, word_done,
    input  finish, elapsed_s, words, wpm, wpm_valid, disp
  );

  modport slave (
    input  state, mode, value, word_done,
    output finish, elapsed_s, words, wpm, wpm_valid, disp
  );

endinterface

// File: rtl/game_session_ctrl_seq_divider.sv
// Unsigned restoring divider (13-bit / 7-bit); done pulses exactly 13 cycles after start.
module seq_divider (
  input  logic        clk_div,
  input  logic        rst,
  input  logic        start,
  input  logic [12:0] dividend,
  input  logic [6:0]  divisor,
  output logic        done,
  output logic [12:0] quotient
);

  logic [12:0] quo_q, quo_d;
  logic [6:0]  rem_q, rem_d;
  logic [6:0]  div_q, div_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  shifted;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[12]};
    if (start) begin
      quo_d  = dividend;
      rem_d  = '0;
      div_d  = divisor;
      cnt_d  = 4'd13;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // The partial remainder is always below the divisor, so 7 bits hold the difference.
      if (shifted >= {1'b0, div_q}) begin
        rem_d = shifted[6:0] - div_q;
        quo_d = {quo_q[11:0], 1'b1};
      end else begin
        rem_d = shifted[6:0];
        quo_d = {quo_q[11:0], 1'b0};
      end
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/game_session_ctrl.sv
// Typing-session controller: counts seconds and words during a game, then
// computes words-per-minute with a sequential divider and formats the display.
module game_session_ctrl
  import game_session_ctrl_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 10,
  parameter int unsigned SAT_MAX       = game_session_ctrl_pkg::SAT_MAX
) (
  input logic                clk_div,
  input logic                rst,
  game_session_ctrl_if.slave bus
);

  localparam int unsigned      TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(SAT_MAX);

  sess_state_e      fsm_q, fsm_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [WPM_W-1:0] wpm_q, wpm_d;
  logic             wpm_valid_q, wpm_valid_d;
  logic             word_prev_q, word_prev_d;
  logic             word_rise_q, word_rise_d;

  logic             complete;
  logic             div_start;
  logic             div_done;
  logic [WPM_W-1:0] div_quotient;
  logic [12:0]      dividend;
  logic [6:0]       divisor;
  logic [CNT_W-1:0] remaining;

  assign complete  = (mode_q == MODE_WORDS) ? (words_q == value_q) : (elapsed_q == value_q);
  assign dividend  = {6'd0, words_q} * 13'd60;
  assign divisor   = (elapsed_q == '0) ? 7'd1 : elapsed_q;
  assign remaining = value_q - ((mode_q == MODE_WORDS) ? words_q : elapsed_q);

  // SELECT aborts from any state; otherwise the session FSM advances.
  always_comb begin
    fsm_d       = fsm_q;
    mode_d      = mode_q;
    value_d     = value_q;
    tick_d      = tick_q;
    elapsed_d   = elapsed_q;
    words_d     = words_q;
    wpm_d       = wpm_q;
    wpm_valid_d = wpm_valid_q;
    word_prev_d = bus.word_done;
    word_rise_d = bus.word_done & ~word_prev_q;
    div_start   = 1'b0;
    if (bus.state == GS_SELECT) begin
      fsm_d       = S_IDLE;
      tick_d      = '0;
      elapsed_d   = '0;
      words_d     = '0;
      wpm_d       = '0;
      wpm_valid_d = 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (bus.state == GS_INGAME) begin
            fsm_d       = S_RUN;
            mode_d      = bus.mode;
            value_d     = bus.value;
            tick_d      = '0;
            elapsed_d   = '0;
            words_d     = '0;
            wpm_d       = '0;
            wpm_valid_d = 1'b0;
          end
        end
        S_RUN: begin
          if (complete) begin
            fsm_d     = S_CALC;
            div_start = 1'b1;
          end else begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              if (elapsed_q != SAT_VAL) elapsed_d = elapsed_q + 7'd1;
            end else begin
              tick_d = tick_q + TW'(1);
            end
            if (word_rise_q && (words_q != SAT_VAL)) words_d = words_q + 7'd1;
          end
        end
        S_CALC: begin
          if (div_done) begin
            fsm_d       = S_DONE;
            wpm_d       = div_quotient;
            wpm_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      fsm_q       <= S_IDLE;
      mode_q      <= MODE_TIME;
      value_q     <= '0;
      tick_q      <= '0;
      elapsed_q   <= '0;
      words_q     <= '0;
      wpm_q       <= '0;
      wpm_valid_q <= 1'b0;
      word_prev_q <= 1'b0;
      word_rise_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      tick_q      <= tick_d;
      elapsed_q   <= elapsed_d;
      words_q     <= words_d;
      wpm_q       <= wpm_d;
      wpm_valid_q <= wpm_valid_d;
      word_prev_q <= word_prev_d;
      word_rise_q <= word_rise_d;
    end
  end

  seq_divider u_div (
    .clk_div  (clk_div),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    bus.disp = BLANK_DISP;
    case (fsm_q)
      S_RUN:   bus.disp = to_bcd({7'd0, remaining});
      S_DONE:  bus.disp = to_bcd({1'b0, wpm_q});
      default: bus.disp = BLANK_DISP;
    endcase
  end

  assign bus.finish    = (fsm_q == S_CALC) || (fsm_q == S_DONE);
  assign bus.elapsed_s = elapsed_q;
  assign bus.words     = words_q;
  assign bus.wpm       = wpm_q;
  assign bus.wpm_valid = wpm_valid_q;

endmodule
